int_to_fp_converter: RTL

- Upstream feeder for the floating-point add/sub unit. Converts a signed or unsigned integer into the team's 32-bit float format: bit31 sign, bits[30:25] 6-bit exponent (bias 31), bits[24:0] fraction with hidden leading 1.
- Multi-cycle FSM with start/busy/done handshake.
- Normalizes one bit per cycle and reports the same status codes as the adder, so results can be driven straight onto op_A_in/op_B_in.

---
 rtl/int_to_fp_converter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/int_to_fp_converter.sv
// Multi-cycle integer to 32-bit float converter (sign, 6-bit exponent, 25-bit fraction).
// Optional macro ROUND_NEAREST_EN: round-to-nearest-even instead of truncation.
module int_to_fp_converter #(
  parameter int INT_W = 32,
  parameter int BIAS  = 31
) (
  input  logic             clock_100kHz,
  input  logic             reset,
  input  logic             start_in,
  input  logic [INT_W-1:0] int_in,
  input  logic             is_signed_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [31:0]      data_out,
  output logic [3:0]       status_out
);

  localparam int         EXT_W    = INT_W + 25;
  localparam logic [6:0] EXP_INIT = 7'(BIAS + INT_W - 1);

  localparam logic [3:0] ST_EXACT    = 4'd0;
  localparam logic [3:0] ST_OVERFLOW = 4'd1;
  localparam logic [3:0] ST_ZERO     = 4'd2;
  localparam logic [3:0] ST_INEXACT  = 4'd3;

  typedef enum logic [1:0] {IDLE, ABS, NORM, PACK} state_t;

  state_t           state;
  logic [INT_W-1:0] mag;
  logic [6:0]       exp_reg;
  logic             sign;
  logic             signed_mode;

  // Extra guard column below the fraction keeps guard/sticky well-defined for small INT_W.
  logic [EXT_W-1:0] ext;
  logic [24:0]      frac_trunc;
  logic             guard;
  logic             sticky;
  logic [24:0]      frac_pack;
  logic [6:0]       exp_pack;
  logic             overflow;
  logic             inexact;
  logic             mag_zero;

  assign ext        = {mag[INT_W-2:0], 26'b0};
  assign frac_trunc = ext[EXT_W-1 -: 25];
  assign guard      = ext[EXT_W-26];
  assign sticky     = |ext[EXT_W-27:0];
  assign mag_zero   = (mag == '0);

`ifdef ROUND_NEAREST_EN
  logic [25:0] frac_sum;

  always_comb begin
    frac_sum  = {1'b0, frac_trunc} + 26'(guard & (sticky | frac_trunc[0]));
    frac_pack = frac_sum[24:0];
    exp_pack  = exp_reg;
    if (frac_sum[25]) begin
      frac_pack = '0;
      exp_pack  = exp_reg + 7'd1;
    end
    overflow = (exp_pack >= 7'd63);
    inexact  = guard | sticky;
  end
`else
  always_comb begin
    frac_pack = frac_trunc;
    exp_pack  = exp_reg;
    overflow  = 1'b0;
    inexact   = guard | sticky;
  end
`endif

  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      mag         <= '0;
      exp_reg     <= '0;
      sign        <= 1'b0;
      signed_mode <= 1'b0;
      busy_out    <= 1'b0;
      done_out    <= 1'b0;
      data_out    <= '0;
      status_out  <= '0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            mag         <= int_in;
            signed_mode <= is_signed_in;
            busy_out    <= 1'b1;
            state       <= ABS;
          end
        end
        ABS: begin
          sign    <= signed_mode & mag[INT_W-1];
          mag     <= (signed_mode & mag[INT_W-1]) ? (~mag + 1'b1) : mag;
          exp_reg <= EXP_INIT;
          state   <= mag_zero ? PACK : NORM;
        end
        NORM: begin
          if (mag[INT_W-1]) begin
            state <= PACK;
          end else begin
            mag     <= mag << 1;
            exp_reg <= exp_reg - 7'd1;
          end
        end
        PACK: begin
          if (mag_zero) begin
            data_out   <= '0;
            status_out <= ST_ZERO;
          end else if (overflow) begin
            data_out   <= {sign, 6'd63, 25'd0};
            status_out <= ST_OVERFLOW;
          end else begin
            data_out   <= {sign, exp_pack[5:0], frac_pack};
            status_out <= inexact ? ST_INEXACT : ST_EXACT;
          end
          done_out <= 1'b1;
          busy_out <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
